// File: rtl/opbyp_pkg.sv
// Shared constants for the decode-stage operand bypass / scoreboard unit.
// Optional build macro: OPBYP_PERF_EN enables the stall cycle counter in operand_bypass_sb.
package opbyp_pkg;

    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;
    localparam int NREG_DEF = 32;
    localparam int NFWD_DEF = 3;

    // Architectural register 0 always reads as zero and is never written.
    localparam int REG_ZERO = 0;

    // Forwarding source indices, youngest first. Lower index wins on a tie.
    localparam int FWD_EXEC = 0;
    localparam int FWD_MEM  = 1;
    localparam int FWD_WB   = 2;

endpackage

// File: rtl/opbyp_scoreboard.sv
// Pending-write scoreboard for long-latency destinations.
// One bit per architectural register; a set and a clear of the same register
// in one cycle leaves the bit set, so a newly issued long op is never lost.
module opbyp_scoreboard
    import opbyp_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    input  logic [AW-1:0] rd_addr3,
    output logic          rd_pend1,
    output logic          rd_pend2,
    output logic          rd_pend3
);

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    // Next pending vector: clear first, then set so that set wins.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            pending_d[set_addr] = 1'b1;
        end
        pending_d[REG_ZERO] = 1'b0;
    end

    // Pending vector register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rd_pend1 = pending_q[rd_addr1];
    assign rd_pend2 = pending_q[rd_addr2];
    assign rd_pend3 = pending_q[rd_addr3];

endmodule

// File: rtl/operand_bypass_sb.sv
// Decode-stage operand fetch/issue: forwarding priority mux, scoreboard and
// load-use stall detection, and a one-deep valid/allow slot toward execute.
// Optional build macro: OPBYP_PERF_EN builds the stall cycle counter;
// without it stall_cnt is tied to zero.
module operand_bypass_sb
    import opbyp_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF,
    parameter int NFWD = NFWD_DEF
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_allow,
    input  logic [AW-1:0]      in_rs,
    input  logic [AW-1:0]      in_rt,
    input  logic               in_use_rs,
    input  logic               in_use_rt,
    input  logic [AW-1:0]      in_dest,
    input  logic               in_long_op,
    output logic [AW-1:0]      rf_raddr1,
    output logic [AW-1:0]      rf_raddr2,
    input  logic [DW-1:0]      rf_rdata1,
    input  logic [DW-1:0]      rf_rdata2,
    input  logic [NFWD-1:0]    fwd_valid,
    input  logic [NFWD-1:0]    fwd_ready,
    input  logic [NFWD*AW-1:0] fwd_dest,
    input  logic [NFWD*DW-1:0] fwd_data,
    input  logic               lop_done,
    input  logic [AW-1:0]      lop_dest,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_allow,
    output logic [DW-1:0]      out_vsrc1,
    output logic [DW-1:0]      out_vsrc2,
    output logic [AW-1:0]      out_dest,
    output logic               out_long_op,
    output logic [31:0]        stall_cnt
);

    logic [NFWD-1:0] hit1;
    logic [NFWD-1:0] hit2;
    logic            rs_zero;
    logic            rt_zero;
    logic            pend_rs;
    logic            pend_rt;
    logic            pend_dest;
    logic            fwd1_found;
    logic            fwd1_ready;
    logic [DW-1:0]   fwd1_data;
    logic            fwd2_found;
    logic            fwd2_ready;
    logic [DW-1:0]   fwd2_data;
    logic            rs_ok;
    logic            rt_ok;
    logic [DW-1:0]   vsrc1_res;
    logic [DW-1:0]   vsrc2_res;
    logic            ops_ready;
    logic            accept;
    logic            sb_set;

    logic            out_valid_q,   out_valid_d;
    logic [DW-1:0]   out_vsrc1_q,   out_vsrc1_d;
    logic [DW-1:0]   out_vsrc2_q,   out_vsrc2_d;
    logic [AW-1:0]   out_dest_q,    out_dest_d;
    logic            out_long_op_q, out_long_op_d;

    assign rf_raddr1 = in_rs;
    assign rf_raddr2 = in_rt;
    assign rs_zero   = (in_rs == AW'(REG_ZERO));
    assign rt_zero   = (in_rt == AW'(REG_ZERO));

    // Per-source match; register 0 never matches since it is never written.
    generate
        for (genvar gi = 0; gi < NFWD; gi++) begin : g_fwd_match
            assign hit1[gi] = fwd_valid[gi] && (fwd_dest[gi*AW +: AW] == in_rs) && !rs_zero;
            assign hit2[gi] = fwd_valid[gi] && (fwd_dest[gi*AW +: AW] == in_rt) && !rt_zero;
        end
    endgenerate

    // Priority select: walk oldest to youngest so the lowest matching index wins.
    always_comb begin
        fwd1_found = 1'b0;
        fwd1_ready = 1'b1;
        fwd1_data  = '0;
        fwd2_found = 1'b0;
        fwd2_ready = 1'b1;
        fwd2_data  = '0;
        for (int i = NFWD - 1; i >= FWD_EXEC; i--) begin
            if (hit1[i]) begin
                fwd1_found = 1'b1;
                fwd1_ready = fwd_ready[i];
                fwd1_data  = fwd_data[i*DW +: DW];
            end
            if (hit2[i]) begin
                fwd2_found = 1'b1;
                fwd2_ready = fwd_ready[i];
                fwd2_data  = fwd_data[i*DW +: DW];
            end
        end
    end

    // Operand resolution and readiness: forwarded value, else register file
    // unless a long op still owns the register.
    always_comb begin
        rs_ok     = 1'b1;
        rt_ok     = 1'b1;
        vsrc1_res = rf_rdata1;
        vsrc2_res = rf_rdata2;
        if (rs_zero) begin
            vsrc1_res = '0;
        end else if (fwd1_found) begin
            vsrc1_res = fwd1_data;
            rs_ok     = !in_use_rs || fwd1_ready;
        end else begin
            rs_ok     = !in_use_rs || !pend_rs;
        end
        if (rt_zero) begin
            vsrc2_res = '0;
        end else if (fwd2_found) begin
            vsrc2_res = fwd2_data;
            rt_ok     = !in_use_rt || fwd2_ready;
        end else begin
            rt_ok     = !in_use_rt || !pend_rt;
        end
    end

    // A second long op to a still-pending register would break one-outstanding-per-register.
    assign ops_ready = rs_ok && rt_ok && !(in_long_op && pend_dest);
    assign in_allow  = !out_valid_q || out_allow;
    assign accept    = in_valid && ops_ready && in_allow && !flush;

    // A long op is committed to the scoreboard when it leaves the slot into execute.
    assign sb_set = out_valid_q && out_allow && out_long_op_q && (out_dest_q != AW'(REG_ZERO));

    opbyp_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clock    (clock),
        .resetn   (resetn),
        .set_en   (sb_set),
        .set_addr (out_dest_q),
        .clr_en   (lop_done),
        .clr_addr (lop_dest),
        .rd_addr1 (in_rs),
        .rd_addr2 (in_rt),
        .rd_addr3 (in_dest),
        .rd_pend1 (pend_rs),
        .rd_pend2 (pend_rt),
        .rd_pend3 (pend_dest)
    );

    // Output slot next state: load on accept, drain on allow, kill on flush.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_vsrc1_d   = out_vsrc1_q;
        out_vsrc2_d   = out_vsrc2_q;
        out_dest_d    = out_dest_q;
        out_long_op_d = out_long_op_q;
        if (accept) begin
            out_valid_d   = 1'b1;
            out_vsrc1_d   = vsrc1_res;
            out_vsrc2_d   = vsrc2_res;
            out_dest_d    = in_dest;
            out_long_op_d = in_long_op;
        end else if (out_allow) begin
            out_valid_d   = 1'b0;
        end
        if (flush) begin
            out_valid_d   = 1'b0;
        end
    end

    // Output slot registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            out_valid_q   <= 1'b0;
            out_vsrc1_q   <= '0;
            out_vsrc2_q   <= '0;
            out_dest_q    <= '0;
            out_long_op_q <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_vsrc1_q   <= out_vsrc1_d;
            out_vsrc2_q   <= out_vsrc2_d;
            out_dest_q    <= out_dest_d;
            out_long_op_q <= out_long_op_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_vsrc1   = out_vsrc1_q;
    assign out_vsrc2   = out_vsrc2_q;
    assign out_dest    = out_dest_q;
    assign out_long_op = out_long_op_q;

`ifdef OPBYP_PERF_EN
    logic        stall;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign stall = in_valid && !ops_ready && !flush;

    // Stall counter increment; wraps naturally at 32 bits.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_operand_bypass_sb.sv
// Directed bench for operand_bypass_sb: stimulus pushes expected operand
// bundles into a queue, a negedge monitor pops and compares on each transfer.
module tb_operand_bypass_sb;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NFWD = 3;

    typedef struct packed {
        logic [DW-1:0] v1;
        logic [DW-1:0] v2;
        logic [AW-1:0] dest;
        logic          lng;
    } exp_t;

    logic               clock = 1'b0;
    logic               resetn;
    logic               in_valid;
    logic               in_allow;
    logic [AW-1:0]      in_rs, in_rt, in_dest;
    logic               in_use_rs, in_use_rt, in_long_op;
    logic [AW-1:0]      rf_raddr1, rf_raddr2;
    logic [DW-1:0]      rf_rdata1, rf_rdata2;
    logic [NFWD-1:0]    fwd_valid, fwd_ready;
    logic [NFWD*AW-1:0] fwd_dest;
    logic [NFWD*DW-1:0] fwd_data;
    logic               lop_done;
    logic [AW-1:0]      lop_dest;
    logic               flush;
    logic               out_valid, out_allow;
    logic [DW-1:0]      out_vsrc1, out_vsrc2;
    logic [AW-1:0]      out_dest;
    logic               out_long_op;
    logic [31:0]        stall_cnt;

    logic [DW-1:0] rf [32];
    exp_t          expq[$];
    int            errors = 0;
    int            checks = 0;
    int            stall_exp = 0;

    always #5 clock = ~clock;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    operand_bypass_sb dut (
        .clock       (clock),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_allow    (in_allow),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_use_rs   (in_use_rs),
        .in_use_rt   (in_use_rt),
        .in_dest     (in_dest),
        .in_long_op  (in_long_op),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .fwd_valid   (fwd_valid),
        .fwd_ready   (fwd_ready),
        .fwd_dest    (fwd_dest),
        .fwd_data    (fwd_data),
        .lop_done    (lop_done),
        .lop_dest    (lop_dest),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_allow   (out_allow),
        .out_vsrc1   (out_vsrc1),
        .out_vsrc2   (out_vsrc2),
        .out_dest    (out_dest),
        .out_long_op (out_long_op),
        .stall_cnt   (stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    function automatic logic [31:0] stall_model();
`ifdef OPBYP_PERF_EN
        return 32'(stall_exp);
`else
        return 32'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [AW-1:0] dest, input logic lng);
        in_rs      = rs;
        in_rt      = rt;
        in_dest    = dest;
        in_long_op = lng;
        in_valid   = 1'b1;
    endtask

    // Issue one instruction expected to be accepted at the next edge.
    task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [AW-1:0] dest, input logic lng,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        expq.push_back('{v1: e1, v2: e2, dest: dest, lng: lng});
        drive(rs, rt, dest, lng);
        step();
        in_valid   = 1'b0;
        in_long_op = 1'b0;
    endtask

    // Monitor: every transfer toward execute must match the oldest expectation.
    always @(negedge clock) begin
        if (resetn && out_valid && out_allow) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL xfer: unexpected output v1=0x%0h v2=0x%0h dest=%0d long=%0b",
                         out_vsrc1, out_vsrc2, out_dest, out_long_op);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if (out_vsrc1 !== e.v1 || out_vsrc2 !== e.v2 ||
                    out_dest !== e.dest || out_long_op !== e.lng) begin
                    errors++;
                    $display("FAIL xfer: got v1=0x%0h v2=0x%0h dest=%0d long=%0b expected v1=0x%0h v2=0x%0h dest=%0d long=%0b",
                             out_vsrc1, out_vsrc2, out_dest, out_long_op, e.v1, e.v2, e.dest, e.lng);
                end else begin
                    $display("xfer v1=0x%0h v2=0x%0h dest=%0d long=%0b", out_vsrc1, out_vsrc2, out_dest, out_long_op);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = 32'h100 + 32'(r);
        rf[0] = 32'h0;
        rf[3] = 32'h11;
        rf[4] = 32'h22;
        resetn = 1'b0; in_valid = 1'b0; in_rs = '0; in_rt = '0; in_dest = '0;
        in_use_rs = 1'b1; in_use_rt = 1'b1; in_long_op = 1'b0;
        fwd_valid = '0; fwd_ready = '1; fwd_dest = '0; fwd_data = '0;
        lop_done = 1'b0; lop_dest = '0; flush = 1'b0; out_allow = 1'b1;

        // Reset state.
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_vsrc1", out_vsrc1, 32'd0);
        chk("rst_vsrc2", out_vsrc2, 32'd0);
        chk("rst_dest", 32'(out_dest), 32'd0);
        chk("rst_long", 32'(out_long_op), 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_in_allow", 32'(in_allow), 32'd1);
        step();
        resetn = 1'b1;
        step();

        // No hazards: register file values.
        drive(5'd3, 5'd4, 5'd6, 1'b0);
        @(negedge clock);
        chk("rf_raddr1", 32'(rf_raddr1), 32'd3);
        chk("rf_raddr2", 32'(rf_raddr2), 32'd4);
        expq.push_back('{v1: 32'h11, v2: 32'h22, dest: 5'd6, lng: 1'b0});
        step();
        in_valid = 1'b0;

        // Forwarding priority.
        fwd_valid = 3'b101;
        fwd_dest[0*AW +: AW] = 5'd5; fwd_data[0*DW +: DW] = 32'hA;
        fwd_dest[2*AW +: AW] = 5'd5; fwd_data[2*DW +: DW] = 32'hC;
        issue(5'd5, 5'd4, 5'd1, 1'b0, 32'hA, 32'h22);
        fwd_valid = 3'b110;
        fwd_dest[1*AW +: AW] = 5'd5; fwd_data[1*DW +: DW] = 32'hB;
        issue(5'd5, 5'd4, 5'd1, 1'b0, 32'hB, 32'h22);
        fwd_valid = 3'b001;
        fwd_dest[0*AW +: AW] = 5'd0; fwd_data[0*DW +: DW] = 32'hDEAD;
        issue(5'd0, 5'd0, 5'd2, 1'b0, 32'h0, 32'h0);
        fwd_valid = 3'b100;
        fwd_dest[2*AW +: AW] = 5'd4; fwd_data[2*DW +: DW] = 32'hC;
        issue(5'd3, 5'd4, 5'd2, 1'b0, 32'h11, 32'hC);
        fwd_valid = '0;

        // Load-use: source 0 not ready for three cycles.
        fwd_valid = 3'b001; fwd_ready = 3'b110;
        fwd_dest[0*AW +: AW] = 5'd7; fwd_data[0*DW +: DW] = 32'h77;
        drive(5'd3, 5'd7, 5'd8, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            @(negedge clock);
            chk("loaduse_no_accept", 32'(out_valid), 32'd0);
            chk("loaduse_in_allow", 32'(in_allow), 32'd1);
        end
        stall_exp += 3;
        fwd_ready = 3'b111;
        expq.push_back('{v1: 32'h11, v2: 32'h77, dest: 5'd8, lng: 1'b0});
        step();
        in_valid = 1'b0; fwd_valid = '0;
        @(negedge clock);
        chk("loaduse_stall_cnt", stall_cnt, stall_model());
        step();

        // Backpressure then flush.
        out_allow = 1'b0;
        issue(5'd3, 5'd4, 5'd11, 1'b0, 32'h11, 32'h22);
        drive(5'd5, 5'd4, 5'd13, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_vsrc1", out_vsrc1, 32'h11);
            chk("bp_dest", 32'(out_dest), 32'd11);
            chk("bp_in_allow", 32'(in_allow), 32'd0);
            step();
        end
        out_allow = 1'b1;
        step();
        out_allow = 1'b0; in_valid = 1'b0; flush = 1'b1;
        @(negedge clock);
        chk("bp_next_loaded", 32'(out_dest), 32'd13);
        step();
        flush = 1'b0;
        @(negedge clock);
        chk("flush_valid", 32'(out_valid), 32'd0);
        out_allow = 1'b1;
        step();

        // Scoreboard: long op to r9, consumer waits for lop_done.
        issue(5'd3, 5'd4, 5'd9, 1'b1, 32'h11, 32'h22);
        step();
        drive(5'd9, 5'd4, 5'd10, 1'b0);
        step();
        step();
        @(negedge clock);
        chk("sb_stall", 32'(out_valid), 32'd0);
        lop_done = 1'b1; lop_dest = 5'd9;
        step();
        lop_done = 1'b0;
        expq.push_back('{v1: 32'h109, v2: 32'h22, dest: 5'd10, lng: 1'b0});
        step();
        in_valid = 1'b0;
        stall_exp += 3;
        @(negedge clock);
        chk("sb_stall_cnt", stall_cnt, stall_model());
        step();

        // Same-cycle set and clear of r9: set wins, consumer stalls.
        issue(5'd3, 5'd4, 5'd9, 1'b1, 32'h11, 32'h22);
        lop_done = 1'b1; lop_dest = 5'd9;
        step();
        lop_done = 1'b0;
        drive(5'd9, 5'd4, 5'd10, 1'b0);
        step();
        step();
        @(negedge clock);
        chk("set_wins_stall", 32'(out_valid), 32'd0);
        drive(5'd3, 5'd4, 5'd9, 1'b1);
        step();
        @(negedge clock);
        chk("waw_stall", 32'(out_valid), 32'd0);
        in_valid = 1'b0; in_long_op = 1'b0;
        step();

        // Reset with pending[9] set and a held output.
        out_allow = 1'b0;
        drive(5'd3, 5'd4, 5'd12, 1'b0);
        step();
        in_valid = 1'b0;
        @(negedge clock);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        step();
        resetn = 1'b0;
        step();
        step();
        @(negedge clock);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_vsrc1", out_vsrc1, 32'd0);
        chk("mid_rst_vsrc2", out_vsrc2, 32'd0);
        chk("mid_rst_dest", 32'(out_dest), 32'd0);
        chk("mid_rst_long", 32'(out_long_op), 32'd0);
        chk("mid_rst_stall", stall_cnt, 32'd0);
        stall_exp = 0;
        step();
        resetn = 1'b1; out_allow = 1'b1;
        issue(5'd9, 5'd4, 5'd10, 1'b0, 32'h109, 32'h22);
        lop_done = 1'b1; lop_dest = 5'd9;
        step();
        lop_done = 1'b0;
        issue(5'd9, 5'd3, 5'd14, 1'b0, 32'h109, 32'h11);
        step();
        step();
        @(negedge clock);
        chk("post_rst_stall", stall_cnt, stall_model());
        chk("queue_drained", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
